// File: rtl/ls_ifill_responder.sv
// rtl/ls_ifill_responder.sv - local-store responder for instruction line buffer refills
//
// Purpose: on a refill request, reads the 128-byte line holding the requested
// PC from the local store as 8 quadword reads. It assembles the line and
// returns it with a one-cycle fill_valid pulse. The read port is released to
// DMA on any cycle where ls_wr_pending is high.
//
// Optional feature: define LS_IFILL_CWF_EN for critical-quadword-first read
// order. Otherwise quadwords are always read 0..7. Latency is the same in both
// builds.
//
// Bit numbering: the vectors are declared descending. The most significant
// bit is the big-endian bit 0. For example, fill_addr[14:7] is the line index.
// Byte 0 of fill_line and of ls_rd_data sits in the most significant byte.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   fill_req        refill request (level), fill_addr = PC of the missing instruction
//   fill_busy       high from acceptance through the fill_valid cycle
//   fill_valid      one-cycle pulse; fill_line / fill_line_addr valid
//   fill_line       assembled 1024-bit line, natural byte order
//   fill_line_addr  line base address
//   ls_rd_en        local store quadword read strobe
//   ls_rd_addr      quadword-aligned read address
//   ls_rd_data      read data, valid the cycle after ls_rd_en
//   ls_wr_pending   DMA write owns the local store port this cycle
module ls_ifill_responder #(
  parameter int LS_ADDR_W = 15,
  parameter int QW_W      = 128,
  parameter int LINE_W    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill_req,
  input  logic [LS_ADDR_W-1:0] fill_addr,
  output logic                 fill_busy,
  output logic                 fill_valid,
  output logic [LINE_W-1:0]    fill_line,
  output logic [LS_ADDR_W-1:0] fill_line_addr,
  output logic                 ls_rd_en,
  output logic [LS_ADDR_W-1:0] ls_rd_addr,
  input  logic [QW_W-1:0]      ls_rd_data,
  input  logic                 ls_wr_pending
);

  localparam int BEATS    = LINE_W / QW_W;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int QW_OFF   = $clog2(QW_W / 8);
  localparam int LINE_OFF = QW_OFF + BEAT_W;
  localparam int QW_LOG   = $clog2(QW_W);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [BEAT_W-1:0] start_beat;
  logic [BEAT_W-1:0] issue_cnt;
  logic [BEAT_W-1:0] issue_beat;
  logic [BEAT_W-1:0] cap_beat;
  logic [BEAT_W-1:0] cap_slot;
  logic              cap_valid;
  logic              accept;
  logic              unused_addr_bits;

  // The issue counter wraps within the line, so the address never leaves the
  // line even when the start beat is non-zero.
  assign issue_beat = start_beat + issue_cnt;
  assign ls_rd_addr = {fill_line_addr[LS_ADDR_W-1:LINE_OFF], issue_beat, {QW_OFF{1'b0}}};
  assign accept     = (state == IDLE) && fill_req;

  // Beat 0 is the most significant quadword of fill_line.
  assign cap_slot = ~cap_beat;

`ifdef LS_IFILL_CWF_EN
  assign unused_addr_bits = ^fill_addr[QW_OFF-1:0];
`else
  assign unused_addr_bits = ^fill_addr[LINE_OFF-1:0];
`endif

  always_comb begin
    state_nxt  = state;
    fill_busy  = (state != IDLE);
    fill_valid = 1'b0;
    ls_rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (fill_req) state_nxt = READ;
      end
      READ: begin
        if (!ls_wr_pending) begin
          ls_rd_en = 1'b1;
          if (issue_cnt == BEAT_W'(BEATS - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        fill_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      start_beat     <= '0;
      issue_cnt      <= '0;
      cap_valid      <= 1'b0;
      cap_beat       <= '0;
      fill_line_addr <= '0;
      fill_line      <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        fill_line_addr <= {fill_addr[LS_ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
`ifdef LS_IFILL_CWF_EN
        start_beat     <= fill_addr[LINE_OFF-1:QW_OFF];
`else
        start_beat     <= '0;
`endif
        issue_cnt      <= '0;
      end else if (ls_rd_en) begin
        issue_cnt <= issue_cnt + BEAT_W'(1);
      end

      // Capture runs one cycle behind issue and ignores ls_wr_pending. It
      // remembers which beat each read was for.
      cap_valid <= ls_rd_en;
      cap_beat  <= issue_beat;
      if (cap_valid) begin
        fill_line[{cap_slot, {QW_LOG{1'b0}}} +: QW_W] <= ls_rd_data;
      end
    end
  end

endmodule
